// File: rtl/lcd_char_rx.sv
// HD44780-style 8-bit bus receiver: 80-byte DDRAM, address counter, display flags, busy/overrun.
// Define LCD_CHAR_RX_READ_EN to enable the bus read path (status and DDRAM reads).
module lcd_char_rx #(
    parameter int EXEC_CYCLES  = 40,
    parameter int CLEAR_CYCLES = 80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs,
    input  logic       rw,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       dout_oe,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cur_on,
    output logic       blink_on,
    output logic       two_line,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, CLR = 2'd2} state_t;

    localparam logic [15:0] EXEC_LAST = 16'(EXEC_CYCLES - 1);
    localparam logic [15:0] CLR_LAST  = 16'(CLEAR_CYCLES - 1);

    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic [6:0]  fill;
    logic        id;
    logic [2:0]  en_s, rs_s, rw_s;
    logic [7:0]  din_s1, din_s2, din_s3;
    logic [7:0]  mem [80];
    logic        fall, wr_stb, wr_cmd, data_wr, ovr_set;

    function automatic logic [6:0] ac_inc(input logic [6:0] a);
        if (a == 7'h27)      return 7'h40;
        else if (a == 7'h67) return 7'h00;
        else                 return a + 7'd1;
    endfunction

    function automatic logic [6:0] ac_dec(input logic [6:0] a);
        if (a == 7'h00)      return 7'h67;
        else if (a == 7'h40) return 7'h27;
        else                 return a - 7'd1;
    endfunction

    function automatic logic ac_valid(input logic [6:0] a);
        return (a <= 7'h27) || (a >= 7'h40 && a <= 7'h67);
    endfunction

    // Line 2 (0x40..0x67) maps onto DDRAM indices 40..79.
    function automatic logic [6:0] ac_index(input logic [6:0] a);
        return a[6] ? ({1'b0, a[5:0]} + 7'd40) : a;
    endfunction

    // Stage 3 holds the last sampled slot with en high when a falling edge is seen.
    assign fall    = en_s[2] & ~en_s[1];
    assign wr_stb  = fall & ~rw_s[2];
    assign busy    = (state != IDLE);
    assign data_wr = wr_cmd & rs_s[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            en_s   <= 3'b000;
            rs_s   <= 3'b000;
            rw_s   <= 3'b000;
            din_s1 <= 8'h00;
            din_s2 <= 8'h00;
            din_s3 <= 8'h00;
        end else begin
            en_s   <= {en_s[1:0], en};
            rs_s   <= {rs_s[1:0], rs};
            rw_s   <= {rw_s[1:0], rw};
            din_s1 <= din;
            din_s2 <= din_s1;
            din_s3 <= din_s2;
        end
    end

    always_comb begin
        state_nxt = state;
        wr_cmd    = 1'b0;
        ovr_set   = 1'b0;
        case (state)
            IDLE: if (wr_stb) begin
                wr_cmd = 1'b1;
                if (!rs_s[2] && din_s3 == 8'h01)     state_nxt = CLR;
                else if (rs_s[2] || din_s3 != 8'h00) state_nxt = EXEC;
            end
            EXEC, CLR: begin
                ovr_set = wr_stb;
                if (cnt == 16'd0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLR;
            cnt      <= CLR_LAST;
            fill     <= 7'd0;
            ac       <= 7'h00;
            id       <= 1'b1;
            disp_on  <= 1'b0;
            cur_on   <= 1'b0;
            blink_on <= 1'b0;
            two_line <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE)       cnt <= (state_nxt == CLR) ? CLR_LAST : EXEC_LAST;
            else if (cnt != 16'd0)   cnt <= cnt - 16'd1;
            if (state == IDLE)                     fill <= 7'd0;
            else if (state == CLR && fill != 7'd80) fill <= fill + 7'd1;
            if (ovr_set) overrun <= 1'b1;
            if (wr_cmd) begin
                if (rs_s[2]) begin
                    ac <= id ? ac_inc(ac) : ac_dec(ac);
                end else begin
                    casez (din_s3)
                        8'b1???????: ac <= ac_valid(din_s3[6:0]) ? din_s3[6:0] : 7'h00;
                        8'b01??????: ;
                        8'b001?????: two_line <= din_s3[3];
                        8'b0001????: if (!din_s3[3]) ac <= din_s3[2] ? ac_inc(ac) : ac_dec(ac);
                        8'b00001???: {disp_on, cur_on, blink_on} <= din_s3[2:0];
                        8'b000001??: id <= din_s3[1];
                        8'b0000001?: ac <= 7'h00;
                        8'b00000001: begin
                            ac <= 7'h00;
                            id <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
`ifdef LCD_CHAR_RX_READ_EN
            else if (fall && rw_s[2] && rs_s[2]) begin
                ac <= id ? ac_inc(ac) : ac_dec(ac);
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (state == CLR && fill < 7'd80) mem[fill] <= 8'h20;
        else if (data_wr)                 mem[ac_index(ac)] <= din_s3;
        rd_data <= (rd_addr < 7'd80) ? mem[rd_addr] : 8'h00;
    end

`ifdef LCD_CHAR_RX_READ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dout    <= 8'h00;
            dout_oe <= 1'b0;
        end else begin
            dout_oe <= en_s[1] & rw_s[1];
            if (en_s[1] && rw_s[1]) dout <= rs_s[1] ? mem[ac_index(ac)] : {busy, ac};
            else                    dout <= 8'h00;
        end
    end
`else
    assign dout    = 8'h00;
    assign dout_oe = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_char_rx.sv
// Self-checking bench for lcd_char_rx: bus strobes from tasks, DDRAM expectations via a scoreboard queue.
module tb_lcd_char_rx;

    logic       clk = 1'b0;
    logic       rst, rs, rw, en;
    logic [7:0] din;
    logic [6:0] rd_addr;
    logic [7:0] dout, rd_data;
    logic       dout_oe;
    logic [6:0] ac;
    logic       disp_on, cur_on, blink_on, two_line, busy, overrun;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] dat;
    } exp_t;
    exp_t sb[$];

    lcd_char_rx #(.EXEC_CYCLES(40), .CLEAR_CYCLES(80)) dut (
        .clk(clk), .rst(rst), .rs(rs), .rw(rw), .en(en), .din(din),
        .dout(dout), .dout_oe(dout_oe), .rd_addr(rd_addr), .rd_data(rd_data),
        .ac(ac), .disp_on(disp_on), .cur_on(cur_on), .blink_on(blink_on),
        .two_line(two_line), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic bus_strobe(input logic rs_v, input logic rw_v, input logic [7:0] d);
        @(negedge clk);
        rs = rs_v; rw = rw_v; din = d; en = 1'b1;
        repeat (4) @(negedge clk);
        en = 1'b0;
    endtask

    task automatic bus_write(input logic rs_v, input logic [7:0] d);
        int n;
        bus_strobe(rs_v, 1'b0, d);
        repeat (4) @(negedge clk);
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++; errors++;
            $display("FAIL write_timeout: busy still %b after %0d cycles, want 0", busy, n);
        end
    endtask

    task automatic bus_read(input logic rs_v, output logic [7:0] d, output logic oe);
        @(negedge clk);
        rs = rs_v; rw = 1'b1; en = 1'b1;
        repeat (4) @(negedge clk);
        d = dout; oe = dout_oe;
        en = 1'b0;
        repeat (4) @(negedge clk);
        rw = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; en = 1'b0; rs = 1'b0; rw = 1'b0; din = 8'h00; rd_addr = 7'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
        checks++; if (ac !== 7'h00) begin errors++; $display("FAIL reset_ac: got %h want 00", ac); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        checks++;
        if ({disp_on, cur_on, blink_on, two_line} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {disp_on, cur_on, blink_on, two_line});
        end
        checks++;
        if (dout !== 8'h00 || dout_oe !== 1'b0) begin
            errors++; $display("FAIL reset_dout: got %h/%b want 00/0", dout, dout_oe);
        end
        n = 0;
        while (busy && n < 300) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n != 80) begin errors++; $display("FAIL reset_busy_len: got %0d want 80", n); end
        for (int i = 0; i < 80; i++) sb.push_back('{addr: 7'(i), dat: 8'h20});
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            rd_addr = e.addr;
            @(negedge clk);
            checks++;
            if (rd_data !== e.dat) begin errors++; $display("FAIL reset_ddram[%0d]: got %h want %h", e.addr, rd_data, e.dat); end
        end
    endtask

    task automatic test_writer_seq();
        logic [7:0] cmds [5];
        logic [7:0] txt [7];
        cmds = '{8'h38, 8'h01, 8'h0E, 8'h06, 8'h80};
        txt  = '{8'h76, 8'h65, 8'h72, 8'h69, 8'h6C, 8'h6F, 8'h67};
        for (int i = 0; i < 5; i++) bus_write(1'b0, cmds[i]);
        for (int i = 0; i < 7; i++) begin
            bus_write(1'b1, txt[i]);
            sb.push_back('{addr: 7'(i), dat: txt[i]});
        end
        sb.push_back('{addr: 7'd7, dat: 8'h20});
        checks++; if (two_line !== 1'b1) begin errors++; $display("FAIL seq_two_line: got %b want 1", two_line); end
        checks++;
        if ({disp_on, cur_on, blink_on} !== 3'b110) begin
            errors++; $display("FAIL seq_flags: got %b want 110", {disp_on, cur_on, blink_on});
        end
        checks++; if (ac !== 7'h07) begin errors++; $display("FAIL seq_ac: got %h want 07", ac); end
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            rd_addr = e.addr;
            @(negedge clk);
            checks++;
            if (rd_data !== e.dat) begin errors++; $display("FAIL seq_ddram[%0d]: got %h want %h", e.addr, rd_data, e.dat); end
        end
    endtask

    task automatic test_read();
        logic [7:0] d;
        logic       oe;
`ifdef LCD_CHAR_RX_READ_EN
        int n;
        bus_strobe(1'b0, 1'b0, 8'h85);
        n = 0;
        while (!busy && n < 10) begin @(negedge clk); n++; end
        bus_read(1'b0, d, oe);
        checks++; if (d !== 8'h85 || oe !== 1'b1) begin errors++; $display("FAIL read_status_busy: got %h/%b want 85/1", d, oe); end
        n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        bus_read(1'b0, d, oe);
        checks++; if (d !== 8'h05) begin errors++; $display("FAIL read_status_idle: got %h want 05", d); end
        bus_write(1'b0, 8'h80);
        bus_read(1'b1, d, oe);
        checks++; if (d !== 8'h76 || oe !== 1'b1) begin errors++; $display("FAIL read_data: got %h/%b want 76/1", d, oe); end
        checks++; if (ac !== 7'h01) begin errors++; $display("FAIL read_data_ac: got %h want 01", ac); end
`else
        bus_read(1'b1, d, oe);
        checks++; if (d !== 8'h00 || oe !== 1'b0) begin errors++; $display("FAIL read_ignored: got %h/%b want 00/0", d, oe); end
        checks++; if (ac !== 7'h07) begin errors++; $display("FAIL read_ignored_ac: got %h want 07", ac); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_ignored_busy: got %b want 0", busy); end
`endif
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL read_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_wrap();
        bus_write(1'b0, 8'hA7);
        bus_write(1'b1, 8'h41);
        bus_write(1'b1, 8'h42);
        sb.push_back('{addr: 7'd39, dat: 8'h41});
        sb.push_back('{addr: 7'd40, dat: 8'h42});
        checks++; if (ac !== 7'h41) begin errors++; $display("FAIL wrap_inc_ac: got %h want 41", ac); end
        bus_write(1'b0, 8'h04);
        bus_write(1'b0, 8'h80);
        bus_write(1'b1, 8'h43);
        sb.push_back('{addr: 7'd0, dat: 8'h43});
        checks++; if (ac !== 7'h67) begin errors++; $display("FAIL wrap_dec_ac: got %h want 67", ac); end
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            rd_addr = e.addr;
            @(negedge clk);
            checks++;
            if (rd_data !== e.dat) begin errors++; $display("FAIL wrap_ddram[%0d]: got %h want %h", e.addr, rd_data, e.dat); end
        end
        bus_write(1'b0, 8'h14);
        checks++; if (ac !== 7'h00) begin errors++; $display("FAIL shift_inc_wrap: got %h want 00", ac); end
        bus_write(1'b0, 8'h10);
        checks++; if (ac !== 7'h67) begin errors++; $display("FAIL shift_dec_wrap: got %h want 67", ac); end
        bus_write(1'b0, 8'hB0);
        checks++; if (ac !== 7'h00) begin errors++; $display("FAIL set_invalid_ac: got %h want 00", ac); end
        bus_write(1'b0, 8'h06);
    endtask

    task automatic test_overrun();
        int n, k, busy_cnt;
        bus_write(1'b0, 8'h85);
        bus_strobe(1'b1, 1'b0, 8'h58);
        n = 0;
        while (!busy && n < 20) begin @(negedge clk); n++; end
        if (!busy) begin
            checks++; errors++;
            $display("FAIL overrun_start: busy got %b want 1", busy);
        end
        busy_cnt = 0;
        k = 0;
        while (busy && k < 200) begin
            busy_cnt++;
            if (k == 1) begin din = 8'h5A; en = 1'b1; end
            if (k == 5) en = 1'b0;
            @(negedge clk);
            k++;
        end
        checks++; if (busy_cnt != 40) begin errors++; $display("FAIL overrun_busy_len: got %0d want 40", busy_cnt); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b want 1", overrun); end
        checks++; if (ac !== 7'h06) begin errors++; $display("FAIL overrun_ac: got %h want 06", ac); end
        sb.push_back('{addr: 7'd5, dat: 8'h58});
        sb.push_back('{addr: 7'd6, dat: 8'h67});
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            rd_addr = e.addr;
            @(negedge clk);
            checks++;
            if (rd_data !== e.dat) begin errors++; $display("FAIL overrun_ddram[%0d]: got %h want %h", e.addr, rd_data, e.dat); end
        end
    endtask

    task automatic test_rst_mid_clear();
        int n;
        bus_strobe(1'b0, 1'b0, 8'h01);
        n = 0;
        while (!busy && n < 20) begin @(negedge clk); n++; end
        repeat (36) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n = 0;
        while (busy && n < 300) begin
            if (n == 4) begin
                checks++;
                if (rd_data !== 8'h42) begin errors++; $display("FAIL restart_fill_idx40: got %h want 42", rd_data); end
            end
            if (n == 3) rd_addr = 7'd40;
            n++;
            @(negedge clk);
        end
        checks++; if (n != 80) begin errors++; $display("FAIL restart_busy_len: got %0d want 80", n); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL restart_overrun: got %b want 0", overrun); end
        checks++; if (ac !== 7'h00) begin errors++; $display("FAIL restart_ac: got %h want 00", ac); end
        checks++; if (two_line !== 1'b0) begin errors++; $display("FAIL restart_two_line: got %b want 0", two_line); end
        for (int i = 0; i < 80; i++) sb.push_back('{addr: 7'(i), dat: 8'h20});
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            rd_addr = e.addr;
            @(negedge clk);
            checks++;
            if (rd_data !== e.dat) begin errors++; $display("FAIL restart_ddram[%0d]: got %h want %h", e.addr, rd_data, e.dat); end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; rs = 1'b0; rw = 1'b0; din = 8'h00; rd_addr = 7'd0;
        test_reset();
        test_writer_seq();
        test_read();
        test_wrap();
        test_overrun();
        test_rst_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
